// File: rtl/vga_timing_generator_pkg.sv
// Shared 640x480@60 timing defaults and the window-membership helper used by
// the scan decode and by the Draw_FSM_* blocks.
package vga_timing_generator_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int POS_W = 16;

  // True when pos lies in the inclusive range lo..hi.
  function automatic logic in_window(input logic [POS_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// Divides the system clock into a registered one-clk pixel_tick pulse every
// CLK_DIV clocks; with CLK_DIV=1 the tick stays high after reset.
module pixel_tick_divider
  import vga_timing_generator_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      pixel_tick <= 1'b0;
    end else if (div == DIV_W'(CLK_DIV - 1)) begin
      div        <= '0;
      pixel_tick <= 1'b1;
    end else begin
      div        <= div + DIV_W'(1);
      pixel_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA scan timing: pixel divider, horizontal/vertical scan counters, and
// registered sync/window/strobe decode aligned with the position buses.
module vga_timing_generator
  import vga_timing_generator_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pixel_tick,
  output logic [POS_W-1:0] horizontal_actual_position,
  output logic [POS_W-1:0] vertical_actual_position,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_VIS_START = H_SYNC + H_BP;
  localparam int H_VIS_END   = H_VIS_START + H_ACTIVE - 1;
  localparam int V_VIS_START = V_SYNC + V_BP;
  localparam int V_VIS_END   = V_VIS_START + V_ACTIVE - 1;

  logic [POS_W-1:0] h_next;
  logic [POS_W-1:0] v_next;

  pixel_tick_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .pixel_tick(pixel_tick)
  );

  always_comb begin
    h_next = horizontal_actual_position + POS_W'(1);
    v_next = vertical_actual_position;
    if (horizontal_actual_position == POS_W'(H_TOTAL - 1)) begin
      h_next = '0;
      if (vertical_actual_position == POS_W'(V_TOTAL - 1)) begin
        v_next = '0;
      end else begin
        v_next = vertical_actual_position + POS_W'(1);
      end
    end
  end

  // Qualifiers are decoded from h_next/v_next so they land in the same cycle
  // as the position they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      horizontal_actual_position <= '0;
      vertical_actual_position   <= '0;
      hsync                      <= SYNC_POL;
      vsync                      <= SYNC_POL;
      video_on                   <= 1'b0;
      line_start                 <= 1'b0;
      frame_start                <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_tick) begin
        horizontal_actual_position <= h_next;
        vertical_actual_position   <= v_next;
        hsync       <= (h_next < POS_W'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (v_next < POS_W'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        video_on    <= in_window(h_next, H_VIS_START, H_VIS_END) &&
                       in_window(v_next, V_VIS_START, V_VIS_END);
        line_start  <= (h_next == '0);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

endmodule
